mmm_r2mm_word_bridge: RTL
=========================

Name: mmm_r2mm_word_bridge

Overview:
- Word-level front/back end for the radix-2 Montgomery multiplier mmm_r2mm_2n.
- Assembles K-bit operands x, y and m from a stream of W-bit words and drives them onto the multiplier. Issues a single-cycle req to the multiplier.
- On val, captures the K-bit result and streams it back out as W-bit words under a valid/ready handshake.
- Sits directly upstream and downstream of mmm_r2mm_2n. Replaces the bench-style wide concatenation with a real load and unload path.

Parameters:
- K, 4096, operand/result width in bits.
- W, 128, word width in bits.
- N, K/W (32), words per operand. K must be an integer multiple of W.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- in_vld  in  1  input word valid.
- in_rdy  out  1  bridge can accept an input word.
- in_sel  in  2  target operand: 0=x, 1=y, 2=m, 3=reserved.
- in_data  in  W  input word.
- start  in  1  request a multiplication, single-cycle pulse.
- busy  out  1  high when state is not IDLE.
- err  out  1  one-cycle pulse: start rejected or in_sel=3 word accepted.
- x  out  K  operand x to the multiplier.
- y  out  K  operand y to the multiplier.
- m  out  K  modulus m to the multiplier.
- mm_req  out  1  multiplier request.
- mm_val  in  1  multiplier result valid.
- mm_res  in  K  multiplier result.
- out_vld  out  1  output word valid.
- out_rdy  in  1  downstream accepts the output word.
- out_data  out  W  output word.
- out_last  out  1  marks word N-1 of the result.

Behaviour:
- All outputs are registered. Reset is synchronous; while rst_n=0 on a clock edge:
  - state goes to IDLE;
  - x, y, m, the result buffer and all counters clear to 0;
  - in_rdy, busy, err, mm_req, out_vld, out_last and out_data clear to 0;
  - loaded mask clears to 3'b000.
- A reset in any state, including mid-multiply or mid-unload, aborts immediately. mm_req drops the same edge, and a later mm_val is ignored.
- in_rdy=1 only in IDLE, starting the first cycle after reset is released.
- Word load: a word is accepted when in_vld & in_rdy.
  - Word i of an operand (i = per-operand write counter) is written to bits [i*W +: W]. Word 0 is the LSW, so words fill LSW first.
  - x, y and m each have their own 5-bit (log2 N) counter.
  - Accepting word N-1 sets that operand's loaded bit and wraps the counter to 0. Further words overwrite from word 0; the loaded bit stays set.
  - in_sel=3: the word is accepted and dropped, no counter changes, err pulses.
- States: IDLE, REQ, WAIT, OUT.
- IDLE -> REQ: on start with loaded=3'b111.
  - start with an incomplete mask: ignored, err pulses, stay in IDLE.
  - start and in_vld in the same cycle: the word is accepted first. start then evaluates the mask as it stands before that word.
- REQ: mm_req=1 for exactly one cycle, then go to WAIT.
- WAIT: on the first cycle with mm_val=1, capture mm_res into the result buffer and go to OUT. mm_val in any other state is ignored.
- x, y and m stay stable from leaving IDLE until re-entering IDLE.
- OUT:
  - out_vld=1; out_data = result word k, starting at k=0 (LSW); out_last=1 when k=N-1.
  - k advances on out_vld & out_rdy.
  - While out_rdy=0, out_data and out_last hold.
  - The handshake on word N-1 returns the bridge to IDLE the next cycle. This clears loaded and the write counters; x, y and m keep their values.
- Latency:
  - start -> mm_req = 1 cycle.
  - mm_val -> first out_vld = 1 cycle.
  - With out_rdy held high, the N words take N consecutive cycles.

Test Plan:
1. Load 32 words each for x, y and m (words 0..31, values = word index), pulse start:
   - mm_req is high exactly one cycle, one cycle after start;
   - x[127:0]=0 and x[4095:3968]=31.
2. Drive mm_val with mm_res = {32 words 0xA0+i} and hold out_rdy=1:
   - out_data gives 0xA0..0xBF on 32 consecutive cycles;
   - out_last is high only with 0xBF;
   - busy falls the cycle after.
3. Toggle out_rdy 1,0,0,1 during OUT:
   - out_data stays constant while out_rdy=0;
   - no word is skipped or duplicated.
4. Load only x and y, pulse start:
   - err pulses once; busy stays 0; mm_req never asserts.
5. Load 33 words into m (word 32 = 0xFFFF):
   - m[127:0]=0xFFFF and the m loaded bit is set;
   - an in_sel=3 word leaves x, y and m unchanged and pulses err.
6. Drop rst_n for 1 cycle while in WAIT, then assert mm_val:
   - bridge sits in IDLE with x=0 and out_vld=0;
   - the late mm_val produces no output.

Source files
------------

// File: rtl/mmm_r2mm_word_bridge.sv
// Word-serial load/unload bridge around the radix-2 Montgomery multiplier: builds x/y/m from W-bit words,
// pulses mm_req, captures the K-bit result on mm_val and streams it out LSW first under valid/ready.
module mmm_r2mm_word_bridge #(
   parameter int K = 4096,
   parameter int W = 128,
   parameter int N = K / W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_vld,
   output logic         in_rdy,
   input  logic [1:0]   in_sel,
   input  logic [W-1:0] in_data,
   input  logic         start,
   output logic         busy,
   output logic         err,
   output logic [K-1:0] x,
   output logic [K-1:0] y,
   output logic [K-1:0] m,
   output logic         mm_req,
   input  logic         mm_val,
   input  logic [K-1:0] mm_res,
   output logic         out_vld,
   input  logic         out_rdy,
   output logic [W-1:0] out_data,
   output logic         out_last
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt_x, cnt_y, cnt_m, k, k_inc;
   logic [2:0]    loaded;
   logic [K-1:0]  res_buf;
   logic          acc, hs, go;

   always_comb begin
      acc       = in_vld & in_rdy;
      hs        = out_vld & out_rdy;
      go        = start & (loaded == 3'b111);
      k_inc     = k + 1'b1;
      state_nxt = state;
      case (state)
         IDLE:    if (go) state_nxt = REQ;
         REQ:     state_nxt = WAIT;
         WAIT:    if (mm_val) state_nxt = OUT;
         OUT:     if (hs && k == LAST) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Status outputs are registered copies of the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x        <= '0;
         y        <= '0;
         m        <= '0;
         res_buf  <= '0;
         cnt_x    <= '0;
         cnt_y    <= '0;
         cnt_m    <= '0;
         k        <= '0;
         loaded   <= 3'b000;
         in_rdy   <= 1'b0;
         busy     <= 1'b0;
         err      <= 1'b0;
         mm_req   <= 1'b0;
         out_vld  <= 1'b0;
         out_last <= 1'b0;
         out_data <= '0;
      end else begin
         in_rdy  <= (state_nxt == IDLE);
         busy    <= (state_nxt != IDLE);
         mm_req  <= (state_nxt == REQ);
         out_vld <= (state_nxt == OUT);
         err     <= (state == IDLE && start && !go) || (acc && in_sel == 2'd3);

         if (acc) begin
            case (in_sel)
               2'd0: begin
                  x[cnt_x*W +: W] <= in_data;
                  if (cnt_x == LAST) begin cnt_x <= '0; loaded[0] <= 1'b1; end
                  else cnt_x <= cnt_x + 1'b1;
               end
               2'd1: begin
                  y[cnt_y*W +: W] <= in_data;
                  if (cnt_y == LAST) begin cnt_y <= '0; loaded[1] <= 1'b1; end
                  else cnt_y <= cnt_y + 1'b1;
               end
               2'd2: begin
                  m[cnt_m*W +: W] <= in_data;
                  if (cnt_m == LAST) begin cnt_m <= '0; loaded[2] <= 1'b1; end
                  else cnt_m <= cnt_m + 1'b1;
               end
               default: ;
            endcase
         end

         if (state == WAIT && mm_val) begin
            res_buf  <= mm_res;
            out_data <= mm_res[W-1:0];
            out_last <= (N == 1);
            k        <= '0;
         end

         // Operands are kept after unload; only the load bookkeeping restarts.
         if (state == OUT && hs) begin
            if (k == LAST) begin
               loaded   <= 3'b000;
               cnt_x    <= '0;
               cnt_y    <= '0;
               cnt_m    <= '0;
               out_last <= 1'b0;
            end else begin
               k        <= k_inc;
               out_data <= res_buf[k_inc*W +: W];
               out_last <= (k_inc == LAST);
            end
         end
      end
   end

endmodule
